// File: rtl/pulse_meter_pkg.sv
// Shared types and default constants for the pulse propagation time meter.
package pulse_meter_pkg;

  localparam int DEF_CNT_W    = 16;
  localparam int DEF_TX_WIDTH = 4;
  localparam int DEF_TIMEOUT  = 1000;
  localparam int DEF_AVG_LOG2 = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TX    = 2'd1,
    WAIT  = 2'd2,
    REARM = 2'd3
  } state_t;

endpackage

// File: rtl/echo_edge_sync.sv
// Three-flop synchronizer for the asynchronous echo level plus rising-edge
// detector. Reusable by any meter channel.
module echo_edge_sync (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Echo,
  output logic o_Edge
);

  logic r1, r2, r3;

  // Shift the raw echo through the synchronizer chain every cycle.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r1 <= 1'b0;
      r2 <= 1'b0;
      r3 <= 1'b0;
    end else begin
      r1 <= i_Echo;
      r2 <= r1;
      r3 <= r2;
    end
  end

  assign o_Edge = r2 & ~r3;

endmodule

// File: rtl/pulse_meter_ctrl.sv
// Measurement sequencer: transmit pulse, count to echo rising edge or timeout.
// Optional burst averaging is enabled by defining PULSE_METER_AVG_EN.
//
// state | meaning
// IDLE  | waiting for i_Start; result strobes are emitted in this state
// TX    | o_Tx high for TX_WIDTH cycles, echo edges blanked
// WAIT  | counting until echo edge or timeout
// REARM | one idle cycle between runs of an averaging burst
module pulse_meter_ctrl
  import pulse_meter_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int TX_WIDTH = DEF_TX_WIDTH,
  parameter int TIMEOUT  = DEF_TIMEOUT
`ifdef PULSE_METER_AVG_EN
  , parameter int AVG_LOG2 = DEF_AVG_LOG2
`endif
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Start,
  input  logic             i_Echo,
  output logic             o_Tx,
  output logic             o_Busy,
  output logic             o_Valid,
  output logic             o_Timeout,
  output logic [CNT_W-1:0] o_Count
);

  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(TX_WIDTH - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] count_d;
  logic             tx_d, busy_d, valid_d, timeout_d;
  logic             echo_edge;

`ifdef PULSE_METER_AVG_EN
  localparam int ACC_W = CNT_W + AVG_LOG2;
  logic [ACC_W-1:0]    acc_q, acc_d, acc_sum;
  logic [AVG_LOG2-1:0] run_q, run_d;
`endif

  echo_edge_sync u_echo_sync (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Echo  (i_Echo),
    .o_Edge  (echo_edge)
  );

  // Register state, counter and all outputs; reset aborts any run at once.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      o_Tx      <= 1'b0;
      o_Busy    <= 1'b0;
      o_Valid   <= 1'b0;
      o_Timeout <= 1'b0;
      o_Count   <= '0;
`ifdef PULSE_METER_AVG_EN
      acc_q     <= '0;
      run_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      o_Tx      <= tx_d;
      o_Busy    <= busy_d;
      o_Valid   <= valid_d;
      o_Timeout <= timeout_d;
      o_Count   <= count_d;
`ifdef PULSE_METER_AVG_EN
      acc_q     <= acc_d;
      run_q     <= run_d;
`endif
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_d      = o_Tx;
    busy_d    = o_Busy;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    count_d   = o_Count;
`ifdef PULSE_METER_AVG_EN
    acc_d     = acc_q;
    run_d     = run_q;
    acc_sum   = acc_q + ACC_W'(cnt_q);
`endif
    case (state_q)
      IDLE: begin
        // A start coinciding with a result strobe is dropped on purpose.
        if (i_Start && !o_Valid && !o_Timeout) begin
          state_d = TX;
          cnt_d   = '0;
          tx_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      TX: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == TX_LAST) begin
          state_d = WAIT;
          tx_d    = 1'b0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Echo takes priority over a coincident timeout.
        if (echo_edge) begin
`ifdef PULSE_METER_AVG_EN
          if (run_q == '1) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b1;
            count_d = CNT_W'(acc_sum >> AVG_LOG2);
            acc_d   = '0;
            run_d   = '0;
          end else begin
            state_d = REARM;
            acc_d   = acc_sum;
            run_d   = run_q + 1'b1;
          end
`else
          state_d = IDLE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          count_d = cnt_q;
`endif
        end else if (cnt_q == TO_LAST) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
          count_d   = TO_VAL;
`ifdef PULSE_METER_AVG_EN
          acc_d     = '0;
          run_d     = '0;
`endif
        end
      end
      REARM: begin
`ifdef PULSE_METER_AVG_EN
        state_d = TX;
        cnt_d   = '0;
        tx_d    = 1'b1;
`else
        state_d = IDLE;
        busy_d  = 1'b0;
`endif
      end
    endcase
  end

endmodule

// File: tb/tb_pulse_meter_ctrl.sv
// Directed bench for pulse_meter_ctrl (TX_WIDTH=4, TIMEOUT=50).
module tb_pulse_meter_ctrl;

  logic        i_Clk   = 1'b0;
  logic        i_Rst_n = 1'b0;
  logic        i_Start = 1'b0;
  logic        i_Echo  = 1'b0;
  logic        o_Tx, o_Busy, o_Valid, o_Timeout;
  logic [15:0] o_Count;

  int errors   = 0;
  int checks   = 0;
  int e        = 0;
  int spurious = 0;
  int tx_rises = 0;
  logic tx_prev;

  always #5 i_Clk = ~i_Clk;

  pulse_meter_ctrl #(
    .CNT_W    (16),
    .TX_WIDTH (4),
    .TIMEOUT  (50)
  ) dut (
    .i_Clk     (i_Clk),
    .i_Rst_n   (i_Rst_n),
    .i_Start   (i_Start),
    .i_Echo    (i_Echo),
    .o_Tx      (o_Tx),
    .o_Busy    (o_Busy),
    .o_Valid   (o_Valid),
    .o_Timeout (o_Timeout),
    .o_Count   (o_Count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
    e++;
  endtask

  task automatic tick_to(input int n);
    while (e < n) tick();
  endtask

  // Start pulse sampled at the next edge, which becomes edge 0.
  task automatic launch();
    i_Start = 1'b1;
    @(posedge i_Clk);
    #1;
    e = 0;
    i_Start = 1'b0;
  endtask

  task automatic settle();
    i_Echo = 1'b0;
    repeat (5) @(posedge i_Clk);
    #1;
  endtask

`ifdef PULSE_METER_AVG_EN
  // One non-final burst run with per-run count c, ending just after REARM->TX.
  task automatic avg_run(input int c);
    tick_to(c - 2);
    i_Echo = 1'b1;
    tick_to(c + 1);
    check("avg_mid_valid", o_Valid, 0);
    check("avg_rearm_busy", o_Busy, 1);
    check("avg_rearm_tx", o_Tx, 0);
    i_Echo = 1'b0;
    tick();
    check("avg_next_tx", o_Tx, 1);
    e = 0;
  endtask
`endif

  initial begin
    #12;
    check("rst_tx", o_Tx, 0);
    check("rst_busy", o_Busy, 0);
    check("rst_valid", o_Valid, 0);
    check("rst_timeout", o_Timeout, 0);
    check("rst_count", o_Count, 0);
    @(negedge i_Clk);
    i_Rst_n = 1'b1;
    @(posedge i_Clk);
    #1;

`ifndef PULSE_METER_AVG_EN
    // Basic measurement: echo sampled at edge 10 -> count 11 after edge 12.
    launch();
    check("basic_tx_e0", o_Tx, 1);
    check("basic_busy_e0", o_Busy, 1);
    tick_to(3);
    check("basic_tx_e3", o_Tx, 1);
    tick_to(4);
    check("basic_tx_e4", o_Tx, 0);
    check("basic_busy_e4", o_Busy, 1);
    tick_to(9);
    i_Echo = 1'b1;
    tick_to(11);
    check("basic_valid_e11", o_Valid, 0);
    tick_to(12);
    check("basic_valid", o_Valid, 1);
    check("basic_count", o_Count, 11);
    check("basic_busy_low", o_Busy, 0);
    check("basic_no_timeout", o_Timeout, 0);
    tick();
    check("basic_valid_once", o_Valid, 0);
    check("basic_count_held", o_Count, 11);
    settle();

    // Earliest legal echo: sampled at edge TX_WIDTH -> count 5 after edge 6.
    launch();
    tick_to(3);
    i_Echo = 1'b1;
    tick_to(6);
    check("edge4_valid", o_Valid, 1);
    check("edge4_count", o_Count, 5);
    settle();

    // Blanking: echo pulse inside TX ignored, real rise at edge 20.
    launch();
    i_Echo = 1'b1;
    tick_to(2);
    i_Echo = 1'b0;
    spurious = 0;
    while (e < 21) begin
      if (e == 19) i_Echo = 1'b1;
      tick();
      if (o_Valid) spurious++;
    end
    check("blank_no_early_valid", spurious, 0);
    tick_to(22);
    check("blank_valid", o_Valid, 1);
    check("blank_count", o_Count, 21);
    settle();

    // Timeout with echo held low.
    launch();
    spurious = 0;
    while (e < 49) begin
      tick();
      if (o_Valid || o_Timeout) spurious++;
    end
    check("to_no_early_strobe", spurious, 0);
    tick_to(50);
    check("to_timeout", o_Timeout, 1);
    check("to_count", o_Count, 50);
    check("to_no_valid", o_Valid, 0);
    check("to_busy_low", o_Busy, 0);
    tick();
    check("to_strobe_once", o_Timeout, 0);
    settle();

    // Start held high across a run: one TX pulse, result-cycle start ignored.
    tx_prev = 1'b0;
    tx_rises = 0;
    i_Start = 1'b1;
    e = -1;
    while (e < 9) begin
      if (e == 5) i_Echo = 1'b1;
      tick();
      if (o_Tx && !tx_prev) tx_rises++;
      tx_prev = o_Tx;
      if (e == 8) begin
        check("busy_start_valid", o_Valid, 1);
        check("busy_start_count", o_Count, 7);
        i_Echo = 1'b0;
      end
    end
    check("busy_start_one_pulse", tx_rises, 1);
    check("busy_start_ignored_tx", o_Tx, 0);
    check("busy_start_ignored_busy", o_Busy, 0);
    tick();
    check("busy_start_relaunch_tx", o_Tx, 1);
    check("busy_start_relaunch_busy", o_Busy, 1);
    i_Start = 1'b0;
    e = 0;
    tick_to(9);
    i_Echo = 1'b1;
    tick_to(12);
    check("relaunch_valid", o_Valid, 1);
    check("relaunch_count", o_Count, 11);
    settle();

    // Reset mid-WAIT at counter 7, then a clean run.
    launch();
    tick_to(7);
    i_Rst_n = 1'b0;
    #1;
    check("mrst_tx", o_Tx, 0);
    check("mrst_busy", o_Busy, 0);
    check("mrst_valid", o_Valid, 0);
    check("mrst_timeout", o_Timeout, 0);
    check("mrst_count", o_Count, 0);
    spurious = 0;
    repeat (3) begin
      @(posedge i_Clk);
      #1;
      if (o_Valid || o_Timeout || o_Busy) spurious++;
    end
    check("mrst_no_strobe", spurious, 0);
    #3;
    i_Rst_n = 1'b1;
    @(posedge i_Clk);
    #1;
    launch();
    tick_to(14);
    i_Echo = 1'b1;
    tick_to(17);
    check("post_rst_valid", o_Valid, 1);
    check("post_rst_count", o_Count, 16);
    settle();
`else
    // Burst of four runs with counts 10, 11, 12, 14 -> average 11.
    launch();
    avg_run(10);
    avg_run(11);
    avg_run(12);
    tick_to(12);
    i_Echo = 1'b1;
    tick_to(15);
    check("avg_valid", o_Valid, 1);
    check("avg_count", o_Count, 11);
    check("avg_busy_low", o_Busy, 0);
    settle();

    // Timeout in the third run aborts the burst.
    launch();
    avg_run(10);
    avg_run(11);
    tick_to(49);
    check("avg_to_busy", o_Busy, 1);
    tick_to(50);
    check("avg_to_timeout", o_Timeout, 1);
    check("avg_to_no_valid", o_Valid, 0);
    check("avg_to_count", o_Count, 50);
    check("avg_to_busy_low", o_Busy, 0);
    settle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_meter_ctrl.md
# pulse_meter_ctrl

Measurement sequencer for the pulse propagation time meter. On a start request it launches a fixed-width transmit pulse, counts clock cycles until the returning echo's rising edge is detected, and reports the count or a timeout. Internally it owns the echo synchronizer and edge detector and hands results to the readout/display logic.

## Interface

- CNT_W, 16: width of the cycle counter and of o_Count.
- TX_WIDTH, 4: o_Tx high time in cycles (≥1); echo edges are ignored while o_Tx is high.
- TIMEOUT, 1000: WAIT-state limit, as a counter value (TX_WIDTH < TIMEOUT < 2^CNT_W).
- AVG_LOG2, 2: log2 of the number of runs averaged, used only with PULSE_METER_AVG_EN.
- i_Clk  in  1  system clock; all logic on its rising edge.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_Start  in  1  single-cycle start request; ignored while o_Busy=1.
- i_Echo  in  1  asynchronous echo level from the receiver.
- o_Tx  out  1  transmit pulse to the line driver.
- o_Busy  out  1  high from TX entry until the result cycle.
- o_Valid  out  1  one-cycle strobe: o_Count holds a new measurement.
- o_Timeout  out  1  one-cycle strobe: no echo before TIMEOUT.
- o_Count  out  CNT_W  last result, held until the next result.

## Operation

- Reset: state IDLE, counter 0, synchronizer flops 0, all outputs 0.
- Echo path: r1<=i_Echo, r2<=r1, r3<=r2; echo_edge = r2 & !r3. Flops run in every state.
- IDLE: i_Start=1 -> TX; counter := 0; o_Tx := 1; o_Busy := 1.
- TX: counter increments every cycle; when counter = TX_WIDTH-1 -> WAIT; o_Tx := 0. echo_edge is ignored (blanking).
- WAIT: counter increments. echo_edge=1 -> o_Count := counter; o_Valid := 1 for one cycle; -> IDLE; o_Busy := 0. Otherwise, when counter = TIMEOUT-1 -> o_Count := TIMEOUT; o_Timeout := 1 for one cycle; -> IDLE.
- If echo_edge and the timeout compare are both true in the same cycle, the echo wins.
- The counter never wraps, because TIMEOUT < 2^CNT_W.
- A reset in any state aborts the run immediately. o_Tx drops asynchronously and no strobe is produced.
- i_Start in the same cycle as o_Valid or o_Timeout is ignored. A new start is accepted from the following cycle.

## Timing

- Index clock edges from the edge that samples i_Start as edge 0. o_Tx is high after edges 0..TX_WIDTH-1 and low after edge TX_WIDTH.
- If i_Echo is first sampled high at edge k (k ≥ TX_WIDTH), then echo_edge is high in the cycle after edge k+1, and o_Valid and o_Count = k+1 appear after edge k+2.
- The fixed +1 offset comes from the synchronizer. Downstream calibration subtracts it.
- With no echo, o_Timeout appears after edge TIMEOUT.
- Strobe outputs are registered, with no combinational input-to-output paths.

## Configuration

- PULSE_METER_AVG_EN undefined: single measurement per start, as above.
- PULSE_METER_AVG_EN defined: one start runs 2^AVG_LOG2 measurements back to back.
  - Each per-run result goes into a (CNT_W+AVG_LOG2)-bit accumulator.
  - After each per-run result, one REARM cycle (o_Busy=1, o_Tx=0) precedes the next TX.
  - o_Valid and o_Count = accumulator >> AVG_LOG2 (truncated) are produced only after the last run.
  - A timeout in any run aborts the burst: o_Timeout pulses, o_Count := TIMEOUT, accumulator cleared.
  - o_Busy stays high for the whole burst.

## Structure

- Shared package pulse_meter_pkg holds the state enum (IDLE, TX, WAIT, REARM) and the default constants CNT_W, TX_WIDTH and TIMEOUT.
- One sub-module, echo_edge_sync: the 3-flop synchronizer plus rising-edge detector, with ports i_Clk, i_Rst_n, i_Echo and o_Edge. It is reusable by other meter channels.

## Test plan

- Basic measurement: TX_WIDTH=4; start; i_Echo rises before edge 10 -> o_Tx high 4 cycles; o_Valid after edge 12 with o_Count=11; o_Busy low the same cycle.
- Blanking: echo pulses during TX, then a real rise sampled at edge 20 -> only one o_Valid, with o_Count=21.
- Timeout: TIMEOUT=50, echo held low -> o_Timeout after edge 50, o_Count=50, no o_Valid.
- Start while busy: i_Start repeated every cycle during a run -> exactly one TX pulse. A start in the result cycle is ignored and a start one cycle later launches a new run.
- Reset mid-WAIT: deassert i_Rst_n at counter=7 -> all outputs 0 immediately, no strobe. After release, a normal run gives the correct count.
- Averaging (macro on, AVG_LOG2=2): echo delays giving per-run counts 10, 11, 12, 14 -> a single o_Valid with o_Count=11. A timeout in run 3 -> o_Timeout, no o_Valid.
